// File: rtl/pio_link_pkg.sv
// pio_link_pkg: shared definitions for the hardware side of the NIOS PIO
// byte handshake.
//   - to_hw_sig command codes (software -> hardware)
//   - to_sw_sig status codes (hardware -> software)
//   - FSM state enum
//   - idx_width(): byte-index width helper (clog2, never less than 1)
// Optional feature macro used by the importing RTL: PIO_LINK_LOOPBACK_EN.
package pio_link_pkg;

  // Software command codes seen on to_hw_sig
  localparam logic [1:0] HW_IDLE = 2'b00;
  localparam logic [1:0] HW_SEND = 2'b01;  // to_hw_port carries a byte
  localparam logic [1:0] HW_REQ  = 2'b10;  // software requests next byte
  localparam logic [1:0] HW_FIN  = 2'b11;  // software acknowledges END

  // Hardware status codes driven on to_sw_sig
  localparam logic [1:0] SW_IDLE = 2'b00;
  localparam logic [1:0] SW_ACK  = 2'b01;  // byte captured
  localparam logic [1:0] SW_DATA = 2'b10;  // to_sw_port carries a byte
  localparam logic [1:0] SW_END  = 2'b11;  // whole packet returned

  typedef enum logic [2:0] {
    RX_WAIT,
    RX_ACK,
    PRESENT,
    RESULT,
    TX_WAIT,
    TX_HOLD,
    TX_END,
    FIN_WAIT
  } state_t;

  // Width of the byte index; a one-byte packet still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pio_link_bytebuf.sv
// pio_link_bytebuf: NBYTES x 8 packet buffer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every byte)
//   wr_en        write wr_byte into byte wr_idx
//   wr_idx       byte index for the single-byte write
//   wr_byte      byte to write
//   load_en      parallel load of all bytes from load_data (wins over wr_en)
//   load_data    flat packet, byte i at [8*i+:8]
//   rd_idx       byte index for the read port
//   rd_byte      byte at rd_idx (combinational read of the register array)
//   flat         whole buffer, byte i at [8*i+:8]
module pio_link_bytebuf
  import pio_link_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [7:0]            wr_byte,
  input  logic                  load_en,
  input  logic [8*NBYTES-1:0]   load_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [7:0]            rd_byte,
  output logic [8*NBYTES-1:0]   flat
);

  // One register per byte; each byte owns its own always_ff so the write
  // decode stays local and no storage is shared between processes.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_reg <= 8'h00;
        end else if (load_en) begin
          byte_reg <= load_data[8*gi +: 8];
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          byte_reg <= wr_byte;
        end
      end

      assign flat[8*gi +: 8] = byte_reg;
    end
  endgenerate

  // Read mux over the flat view; an index past NBYTES-1 reads zero.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_byte = flat[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/pio_link_hw.sv
// pio_link_hw: hardware endpoint of the NIOS PIO byte handshake.
// Receives an NBYTES packet from software byte by byte (four-phase
// SEND/ACK handshake), presents it to a downstream core with valid/ready,
// takes the core's NBYTES result with valid/ready and returns it to
// software byte by byte (REQ/DATA handshake), closing with END/FIN.
// Ports:
//   clk, reset_n          SoC clock, asynchronous active-low reset
//   to_hw_port/to_hw_sig  byte and command code from software
//   to_sw_port/to_sw_sig  byte and status code to software (registered)
//   rx_data/rx_valid      received packet to core; rx_ready from core
//   tx_data/tx_valid      result packet from core; tx_ready to core
// Optional feature: define PIO_LINK_LOOPBACK_EN to skip PRESENT/RESULT and
// echo the received packet straight back (rx_valid/tx_ready stay 0).
module pio_link_hw
  import pio_link_pkg::*;
#(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            to_hw_port,
  input  logic [1:0]            to_hw_sig,
  output logic [7:0]            to_sw_port,
  output logic [1:0]            to_sw_sig,
  output logic [8*NBYTES-1:0]   rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [8*NBYTES-1:0]   tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready
);

  localparam int              IDX_W    = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // Software inputs are sampled once; the FSM only looks at these copies.
  logic [1:0]        sig_q;
  logic [7:0]        port_q;

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [7:0]        to_sw_port_reg;
  logic [1:0]        to_sw_sig_reg;
  logic              rx_valid_reg;
  logic              tx_ready_reg;

  logic              buf_wr_en;
  logic              buf_load_en;
  logic [7:0]        buf_rd_byte;

  // The byte is written on the same edge the FSM raises ACK.
  assign buf_wr_en = (state_reg == RX_WAIT) && (sig_q == HW_SEND);

`ifdef PIO_LINK_LOOPBACK_EN
  assign buf_load_en = 1'b0;
  // Core-side inputs have no function in loopback.
  logic unused_core_inputs;
  assign unused_core_inputs = ^{tx_data, tx_valid, rx_ready};
`else
  assign buf_load_en = (state_reg == RESULT) && tx_valid && tx_ready_reg;
`endif

  pio_link_bytebuf #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_bytebuf (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_en     (buf_wr_en),
    .wr_idx    (idx_reg),
    .wr_byte   (port_q),
    .load_en   (buf_load_en),
    .load_data (tx_data),
    .rd_idx    (idx_reg),
    .rd_byte   (buf_rd_byte),
    .flat      (rx_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q          <= HW_IDLE;
      port_q         <= 8'h00;
      state_reg      <= RX_WAIT;
      idx_reg        <= '0;
      to_sw_port_reg <= 8'h00;
      to_sw_sig_reg  <= SW_IDLE;
      rx_valid_reg   <= 1'b0;
      tx_ready_reg   <= 1'b0;
    end else begin
      sig_q  <= to_hw_sig;
      port_q <= to_hw_port;

      case (state_reg)
        // REQ and FIN are deliberately ignored while waiting for a byte.
        RX_WAIT: begin
          if (sig_q == HW_SEND) begin
            to_sw_sig_reg <= SW_ACK;
            state_reg     <= RX_ACK;
          end
        end

        RX_ACK: begin
          if (sig_q == HW_IDLE) begin
            to_sw_sig_reg <= SW_IDLE;
            if (idx_reg == LAST_IDX) begin
              idx_reg <= '0;
`ifdef PIO_LINK_LOOPBACK_EN
              state_reg <= TX_WAIT;
`else
              rx_valid_reg <= 1'b1;
              state_reg    <= PRESENT;
`endif
            end else begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= RX_WAIT;
            end
          end
        end

`ifndef PIO_LINK_LOOPBACK_EN
        // rx_ready may already be high on the first valid cycle.
        PRESENT: begin
          if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
            tx_ready_reg <= 1'b1;
            state_reg    <= RESULT;
          end
        end

        // The buffer itself is loaded through buf_load_en on this edge.
        RESULT: begin
          if (tx_valid && tx_ready_reg) begin
            tx_ready_reg <= 1'b0;
            state_reg    <= TX_WAIT;
          end
        end
`endif

        TX_WAIT: begin
          if (sig_q == HW_REQ) begin
            to_sw_port_reg <= buf_rd_byte;
            to_sw_sig_reg  <= SW_DATA;
            state_reg      <= TX_HOLD;
          end
        end

        // After the last byte, END replaces the IDLE release directly.
        TX_HOLD: begin
          if (sig_q == HW_IDLE) begin
            if (idx_reg == LAST_IDX) begin
              to_sw_sig_reg <= SW_END;
              state_reg     <= TX_END;
            end else begin
              to_sw_sig_reg <= SW_IDLE;
              idx_reg       <= idx_reg + IDX_W'(1);
              state_reg     <= TX_WAIT;
            end
          end
        end

        TX_END: begin
          if (sig_q == HW_FIN) begin
            to_sw_sig_reg <= SW_IDLE;
            idx_reg       <= '0;
            state_reg     <= FIN_WAIT;
          end
        end

        // Software must drop FIN before a new SEND can be recognised.
        FIN_WAIT: begin
          if (sig_q == HW_IDLE) begin
            state_reg <= RX_WAIT;
          end
        end

        default: begin
          state_reg <= RX_WAIT;
        end
      endcase
    end
  end

  assign to_sw_port = to_sw_port_reg;
  assign to_sw_sig  = to_sw_sig_reg;
  assign rx_valid   = rx_valid_reg;
  assign tx_ready   = tx_ready_reg;

endmodule

// File: tb/tb_pio_link_hw.sv
// tb_pio_link_hw: directed self-checking bench for pio_link_hw (NBYTES=16).
// Default build exercises the full RX -> core -> TX flow; with
// PIO_LINK_LOOPBACK_EN defined it exercises the echo path instead.
module tb_pio_link_hw;

  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      to_hw_port = 8'h00;
  logic [1:0]      to_hw_sig = 2'b00;
  logic [7:0]      to_sw_port;
  logic [1:0]      to_sw_sig;
  logic [8*NB-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ready = 1'b0;
  logic [8*NB-1:0] tx_data = '0;
  logic            tx_valid = 1'b0;
  logic            tx_ready;

  int tests = 0;
  int failed = 0;

  pio_link_hw #(.NBYTES(NB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .to_hw_port (to_hw_port),
    .to_hw_sig  (to_hw_sig),
    .to_sw_port (to_sw_port),
    .to_sw_sig  (to_sw_sig),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet whose byte i is base+i.
  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'(base + 8'(i));
    return r;
  endfunction

  // Poll to_sw_sig on falling edges with a cycle bound; an expired bound
  // shows up as a failed comparison.
  task automatic wait_sig(input logic [1:0] v, input string tag);
    int n;
    n = 0;
    while (to_sw_sig !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {126'd0, to_sw_sig}, {126'd0, v});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    to_hw_port = b;
    to_hw_sig  = 2'b01;
    wait_sig(2'b01, "send_ack");
    to_hw_sig = 2'b00;
    wait_sig(2'b00, "send_ack_clr");
  endtask

  task automatic recv_byte(input logic [7:0] exp, input bit last);
    @(negedge clk);
    to_hw_sig = 2'b10;
    wait_sig(2'b10, "recv_data");
    check("recv_byte", {120'd0, to_sw_port}, {120'd0, exp});
    to_hw_sig = 2'b00;
    wait_sig(last ? 2'b11 : 2'b00, last ? "recv_end" : "recv_clr");
  endtask

  task automatic finish_fin();
    @(negedge clk);
    to_hw_sig = 2'b11;
    wait_sig(2'b00, "fin_clr");
    to_hw_sig = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sig", {126'd0, to_sw_sig}, 128'd0);
    check("rst_port", {120'd0, to_sw_port}, 128'd0);
    check("rst_rx_valid", {127'd0, rx_valid}, 128'd0);
    check("rst_tx_ready", {127'd0, tx_ready}, 128'd0);
    check("rst_rx_data", rx_data, 128'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef PIO_LINK_LOOPBACK_EN
    rx_ready = 1'b1;
    for (int i = 0; i < NB; i++) begin
      send_byte(8'(8'h10 + 8'(i)));
      check("lb_rx_valid", {127'd0, rx_valid}, 128'd0);
    end
    check("lb_buffer", rx_data, ramp(8'h10));
    check("lb_tx_ready", {127'd0, tx_ready}, 128'd0);
    for (int i = 0; i < NB; i++) recv_byte(8'(8'h10 + 8'(i)), i == NB - 1);
    check("lb_rx_valid_end", {127'd0, rx_valid}, 128'd0);
    finish_fin();
`else
    // Packet 0x00..0x0F, rx_ready held high; first byte checks k+2 latency
    rx_ready = 1'b1;
    @(negedge clk);
    to_hw_port = 8'h00;
    to_hw_sig  = 2'b01;
    @(negedge clk);
    check("lat_k1", {126'd0, to_sw_sig}, 128'd0);
    @(negedge clk);
    check("lat_k2", {126'd0, to_sw_sig}, 128'd1);
    to_hw_sig = 2'b00;
    wait_sig(2'b00, "send_ack_clr");
    for (int i = 1; i < NB; i++) send_byte(8'(i));
    check("rx_valid_pulse", {127'd0, rx_valid}, 128'd1);
    check("rx_data_ramp", rx_data, 128'h0F0E0D0C0B0A09080706050403020100);
    @(negedge clk);
    check("rx_valid_drop", {127'd0, rx_valid}, 128'd0);
    check("tx_ready_up", {127'd0, tx_ready}, 128'd1);

    // Result 0xA5 x16, tx_valid two cycles after tx_ready
    @(negedge clk);
    check("tx_ready_wait", {127'd0, tx_ready}, 128'd1);
    @(negedge clk);
    tx_data  = {16{8'hA5}};
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_drop", {127'd0, tx_ready}, 128'd0);
    check("tx_loaded", rx_data, {16{8'hA5}});
    for (int i = 0; i < NB; i++) recv_byte(8'hA5, i == NB - 1);
    finish_fin();
    check("port_kept", {120'd0, to_sw_port}, 128'hA5);

    // Stray REQ/FIN in RX_WAIT
    to_hw_port = 8'hEE;
    to_hw_sig  = 2'b10;
    repeat (6) @(negedge clk);
    check("stray_req_sig", {126'd0, to_sw_sig}, 128'd0);
    to_hw_sig = 2'b11;
    repeat (6) @(negedge clk);
    check("stray_fin_sig", {126'd0, to_sw_sig}, 128'd0);
    check("stray_no_write", rx_data, {16{8'hA5}});
    to_hw_sig = 2'b00;
    repeat (3) @(negedge clk);

    // Back-pressure: rx_ready low 20 cycles, tx_valid pulse ignored
    rx_ready = 1'b0;
    for (int i = 0; i < NB; i++) send_byte(8'(8'h20 + 8'(i)));
    for (int c = 0; c < 20; c++) begin
      if (c == 4) begin
        tx_data  = {16{8'hDE}};
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
      if (c % 5 == 4) begin
        check("bp_rx_valid", {127'd0, rx_valid}, 128'd1);
        check("bp_tx_ready", {127'd0, tx_ready}, 128'd0);
        check("bp_rx_data", rx_data, ramp(8'h20));
      end
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("bp_release_valid", {127'd0, rx_valid}, 128'd0);
    check("bp_release_ready", {127'd0, tx_ready}, 128'd1);
    tx_data  = ramp(8'h50);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("bp_tx_ready_drop", {127'd0, tx_ready}, 128'd0);
    for (int i = 0; i < NB; i++) recv_byte(8'(8'h50 + 8'(i)), i == NB - 1);
    finish_fin();

    // Reset in the middle of byte 7 of a packet
    rx_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + 8'(i)));
    @(negedge clk);
    to_hw_port = 8'h37;
    to_hw_sig  = 2'b01;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_sig", {126'd0, to_sw_sig}, 128'd0);
    check("mid_rst_port", {120'd0, to_sw_port}, 128'd0);
    check("mid_rst_rx_data", rx_data, 128'd0);
    check("mid_rst_rx_valid", {127'd0, rx_valid}, 128'd0);
    check("mid_rst_tx_ready", {127'd0, tx_ready}, 128'd0);
    to_hw_sig = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NB; i++) send_byte(8'(8'h40 + 8'(i)));
    check("post_rst_valid", {127'd0, rx_valid}, 128'd1);
    check("post_rst_rx_data", rx_data, ramp(8'h40));
    @(negedge clk);
    check("post_rst_tx_ready", {127'd0, tx_ready}, 128'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
